bka_pipe_adder: RTL
===================

// Module: bka_pipe_adder
// PURPOSE
//  Parametrised, pipelined Brent-Kung prefix adder/subtractor with valid/ready flow control.
//  Successor to the fixed 16-bit combinational Brent-Kung adder.
//  Generalised in width, with optional subtract mode, signed-overflow flag and 1-3 register stages.
//  Sits in datapaths that need a registered wide add with backpressure, e.g. the accumulator and address units.
// PARAMETERS
//  WIDTH   32  operand/result width in bits; must be a power of two, 4..64
//  STAGES  2   register stages, 1..3; equals the latency in cycles
// PORTS
//  clk        in   1      single clock, rising edge
//  rst_n      in   1      synchronous reset, active-low
//  in_valid   in   1      input transaction valid
//  in_ready   out  1      block can accept an input this cycle
//  in_a       in   WIDTH  operand A
//  in_b       in   WIDTH  operand B
//  in_cin     in   1      carry-in; ignored when in_sub=1
//  in_sub     in   1      0: A+B+cin; 1: A-B (A + ~B + 1)
//  out_valid  out  1      result valid
//  out_ready  in   1      downstream accepts the result
//  out_sum    out  WIDTH  result
//  out_cout   out  1      carry out of bit WIDTH-1 (for subtract: 1 = no borrow)
//  out_ovf    out  1      two's-complement signed overflow
// BEHAVIOUR
//  - Reset: all stage valid bits clear. out_valid=0, out_sum=0, out_cout=0, out_ovf=0.
//    in_ready=1 in the first cycle after reset deasserts.
//  - Transfer: input is accepted when in_valid & in_ready; output is consumed when out_valid & out_ready.
//  - Global stall: en = !out_valid | out_ready. in_ready = en.
//    All pipeline registers, data and valid, load only when en=1. Bubbles do not collapse.
//  - Latency: an input accepted in cycle N appears on out_* in cycle N+STAGES, if no stall occurs.
//    Every stall cycle adds one cycle.
//  - Throughput: 1 result per cycle while out_ready=1.
//  - Datapath:
//    - b' = in_sub ? ~in_b : in_b; c0 = in_sub ? 1 : in_cin.
//    - Bitwise p = a^b', g = a&b'.
//    - Brent-Kung up-sweep of log2(WIDTH) levels, then down-sweep of log2(WIDTH)-1 levels.
//    - Carries: c[i+1] = G[i:0] | P[i:0]&c0. sum[i] = p[i]^c[i].
//  - Stage cut points:
//    - STAGES=1: register at the output only.
//    - STAGES=2: adds a register after the up-sweep (group P/G, p, c0 carried forward).
//    - STAGES=3: also adds a register after bitwise p/g generation.
//  - Flags:
//    - out_cout = c[WIDTH].
//    - out_ovf = c[WIDTH] ^ c[WIDTH-1], i.e. the signed overflow of a + b' + c0.
//  - Output stability: while out_valid=1 & out_ready=0, out_sum/out_cout/out_ovf hold their values.
//  - Data registers are don't-care when their valid bit is 0. Only out_* are forced to 0 at reset.
//  - Reset mid-operation: all in-flight transactions are discarded. No result for them is emitted after reset.
//  - in_valid=0 while en=1 inserts a bubble (stage valid bit = 0).
//  - Full: all STAGES slots valid and out_ready=0 gives in_ready=0.
//    Simultaneous accept and consume in one cycle is legal and loses nothing.
// TESTING
//  T1 WIDTH=16, STAGES=1: a=0xFFFF, b=0x0001, cin=0, sub=0 -> next cycle sum=0x0000, cout=1, ovf=0.
//  T2 WIDTH=32, STAGES=2: a=0x7FFFFFFF, b=1, sub=0 -> after 2 cycles sum=0x80000000, cout=0, ovf=1.
//     Then a=5, b=7, sub=1 -> sum=0xFFFFFFFE, cout=0, ovf=0.
//  T3 STAGES=3, out_ready=0, stream 5 back-to-back inputs:
//     -> exactly 3 accepted, then in_ready=0 and out_sum held stable.
//     Release out_ready -> results emerge in order, none lost or duplicated.
//  T4 Random in_valid/out_ready (50% each), 10k vectors per (WIDTH,STAGES) in {4,16,32,64}x{1,2,3}
//     -> every result matches the reference model {cout,sum} = a + b' + c0, and ovf matches; order preserved.
//  T5 Assert rst_n=0 for 1 cycle with 2 transactions in flight
//     -> out_valid=0 and outputs zero next cycle, the in-flight results never appear, in_ready=1.
//  T6 WIDTH=64: a=0x8000000000000000, b=1, sub=1 -> sum=0x7FFFFFFFFFFFFFFF, cout=1, ovf=1.

Source files
------------

// File: rtl/bka_pipe_adder.sv
// Pipelined Brent-Kung prefix adder/subtractor with valid/ready flow control.
// Optional cuts after bitwise p/g generation and after the up-sweep; the output is always registered.
module bka_pipe_adder #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf
);

  localparam int unsigned LOG_W = $clog2(WIDTH);

  // Up-sweep: combines aligned power-of-two groups in place; returns {P, G}.
  function automatic logic [2*WIDTH-1:0] up_sweep(input logic [WIDTH-1:0] p,
                                                  input logic [WIDTH-1:0] g);
    logic [WIDTH-1:0] pp;
    logic [WIDTH-1:0] gg;
    int unsigned      step;
    int unsigned      half;
    pp = p;
    gg = g;
    for (int unsigned l = 0; l < LOG_W; l++) begin
      half = 32'd1 << l;
      step = 32'd2 << l;
      for (int unsigned i = step - 1; i < WIDTH; i += step) begin
        gg[i] = gg[i] | (pp[i] & gg[i-half]);
        pp[i] = pp[i] & pp[i-half];
      end
    end
    return {pp, gg};
  endfunction

  // Down-sweep: fills in the remaining prefixes so every bit holds [i:0].
  function automatic logic [2*WIDTH-1:0] down_sweep(input logic [WIDTH-1:0] p,
                                                    input logic [WIDTH-1:0] g);
    logic [WIDTH-1:0] pp;
    logic [WIDTH-1:0] gg;
    int unsigned      l;
    int unsigned      step;
    int unsigned      half;
    pp = p;
    gg = g;
    for (int unsigned k = 0; k < LOG_W - 1; k++) begin
      l    = LOG_W - 2 - k;
      half = 32'd1 << l;
      step = 32'd2 << l;
      for (int unsigned i = step + half - 1; i < WIDTH; i += step) begin
        gg[i] = gg[i] | (pp[i] & gg[i-half]);
        pp[i] = pp[i] & pp[i-half];
      end
    end
    return {pp, gg};
  endfunction

  logic             w_en;
  logic [WIDTH-1:0] w_b;
  logic [WIDTH-1:0] w_p0;
  logic [WIDTH-1:0] w_g0;
  logic             w_c00;

  // Global stall: every register in the pipe advances together.
  assign w_en     = !out_valid || out_ready;
  assign in_ready = w_en;

  assign w_b   = in_sub ? ~in_b : in_b;
  assign w_c00 = in_sub | in_cin;
  assign w_p0  = in_a ^ w_b;
  assign w_g0  = in_a & w_b;

  logic [WIDTH-1:0] w_pa;
  logic [WIDTH-1:0] w_ga;
  logic             w_c0a;
  logic             w_va;

  generate
    if (STAGES >= 3) begin : g_cut_pg
      logic [WIDTH-1:0] r_p;
      logic [WIDTH-1:0] r_g;
      logic             r_c0;
      logic             r_v;
      always_ff @(posedge clk) begin
        if (!rst_n)    r_v <= 1'b0;
        else if (w_en) r_v <= in_valid;
      end
      always_ff @(posedge clk) begin
        if (w_en) begin
          r_p  <= w_p0;
          r_g  <= w_g0;
          r_c0 <= w_c00;
        end
      end
      assign w_pa  = r_p;
      assign w_ga  = r_g;
      assign w_c0a = r_c0;
      assign w_va  = r_v;
    end else begin : g_no_cut_pg
      assign w_pa  = w_p0;
      assign w_ga  = w_g0;
      assign w_c0a = w_c00;
      assign w_va  = in_valid;
    end
  endgenerate

  logic [2*WIDTH-1:0] w_up;
  logic [WIDTH-1:0]   w_pb;
  logic [WIDTH-1:0]   w_grp_pb;
  logic [WIDTH-1:0]   w_grp_gb;
  logic               w_c0b;
  logic               w_vb;

  assign w_up = up_sweep(w_pa, w_ga);

  generate
    if (STAGES >= 2) begin : g_cut_up
      logic [WIDTH-1:0] r_p;
      logic [WIDTH-1:0] r_grp_p;
      logic [WIDTH-1:0] r_grp_g;
      logic             r_c0;
      logic             r_v;
      always_ff @(posedge clk) begin
        if (!rst_n)    r_v <= 1'b0;
        else if (w_en) r_v <= w_va;
      end
      always_ff @(posedge clk) begin
        if (w_en) begin
          r_p     <= w_pa;
          r_grp_p <= w_up[2*WIDTH-1:WIDTH];
          r_grp_g <= w_up[WIDTH-1:0];
          r_c0    <= w_c0a;
        end
      end
      assign w_pb     = r_p;
      assign w_grp_pb = r_grp_p;
      assign w_grp_gb = r_grp_g;
      assign w_c0b    = r_c0;
      assign w_vb     = r_v;
    end else begin : g_no_cut_up
      assign w_pb     = w_pa;
      assign w_grp_pb = w_up[2*WIDTH-1:WIDTH];
      assign w_grp_gb = w_up[WIDTH-1:0];
      assign w_c0b    = w_c0a;
      assign w_vb     = w_va;
    end
  endgenerate

  logic [2*WIDTH-1:0] w_dn;
  logic [WIDTH:0]     w_carry;

  // c[i+1] = G[i:0] | P[i:0] & c0, with c[0] = c0.
  assign w_dn    = down_sweep(w_grp_pb, w_grp_gb);
  assign w_carry = {w_dn[WIDTH-1:0] | (w_dn[2*WIDTH-1:WIDTH] & {WIDTH{w_c0b}}), w_c0b};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_cout  <= 1'b0;
      out_ovf   <= 1'b0;
    end else if (w_en) begin
      out_valid <= w_vb;
      out_sum   <= w_pb ^ w_carry[WIDTH-1:0];
      out_cout  <= w_carry[WIDTH];
      out_ovf   <= w_carry[WIDTH] ^ w_carry[WIDTH-1];
    end
  end

endmodule
